ps2_key_fifo: RTL and testbench



---
 rtl/ps2_key_fifo.sv | 219 +++++++++++++++++++++
 tb/tb_ps2_key_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: PS/2 keyboard receiver with frame checking, E0/F0 prefix folding
// and a first-word-fall-through key-event FIFO.
// Optional feature macro: PS2_BREAK_EVENTS_EN (queue key-release events).
module ps2_key_fifo #(
  parameter int DEPTH   = 8,
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 1600
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd_en,
  output logic                     ev_valid,
  output logic [7:0]               ev_code,
  output logic                     ev_break,
  output logic                     ev_ext,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

`ifdef PS2_BREAK_EVENTS_EN
  localparam logic BRK_EN = 1'b1;
`else
  localparam logic BRK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f;
  logic [FW-1:0] fcnt;
  logic          strobe;

  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          byte_valid;
  logic [7:0]    rx_byte;

  logic          ext_f, brk_f;
  logic          ev_push;
  logic [9:0]    ev_word;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [9:0]    head;
  logic          full, do_pop, do_push;

  // Two-flop synchronisers for both PS/2 pins; idle level of the bus is high.
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Stability filter on ps2_clk; the strobe is raised together with an accepted fall.
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_f  <= 1'b1;
      fcnt   <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_s2 != clk_f) begin
        if (fcnt == FW'(FILTER - 1)) begin
          clk_f  <= clk_s2;
          fcnt   <= '0;
          strobe <= clk_f;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop, with inter-bit timeout.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end
          DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          default: begin
            if (dat_s2 && ((^shreg) ^ par)) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          state     <= IDLE;
          tcnt      <= '0;
          frame_err <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  // Prefix decoder: folds E0/F0 into the next real scan code; 00/FF are dropped.
  always_ff @(posedge CLK) begin
    if (reset) begin
      ext_f   <= 1'b0;
      brk_f   <= 1'b0;
      ev_push <= 1'b0;
      ev_word <= '0;
    end else begin
      ev_push <= 1'b0;
      if (byte_valid) begin
        case (rx_byte)
          8'hE0: ext_f <= 1'b1;
          8'hF0: brk_f <= 1'b1;
          8'h00, 8'hFF: begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end
          default: begin
            ev_word <= {ext_f, brk_f, rx_byte};
            ev_push <= BRK_EN | ~brk_f;
            ext_f   <= 1'b0;
            brk_f   <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO handshake: a pop frees a slot for a same-cycle push when full.
  always_comb begin
    full    = (count == CW'(DEPTH));
    do_pop  = rd_en && (count != '0);
    do_push = ev_push && (!full || do_pop);
    head    = mem[rd_ptr];
  end

  // FIFO storage; contents need no reset because outputs are masked by ev_valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= ev_word;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ev_push && full && !do_pop) overflow <= 1'b1;
    end
  end

  // Head-of-queue outputs, forced to zero while empty.
  always_comb begin
    ev_valid = (count != '0);
    ev_code  = ev_valid ? head[7:0] : '0;
    ev_ext   = ev_valid & head[9];
    ev_break = BRK_EN & ev_valid & head[8];
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Self-checking bench for ps2_key_fifo: directed scenarios plus randomized frames
// compared against a queue-based reference model of the decoder and FIFO.
module tb_ps2_key_fifo;

  localparam int DEPTH   = 8;
  localparam int FILTER  = 4;
  localparam int TIMEOUT = 1600;
`ifdef PS2_BREAK_EVENTS_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       reset, ps2_clk, ps2_data, rd_en;
  logic       ev_valid, ev_break, ev_ext, overflow, frame_err;
  logic [7:0] ev_code;
  logic [$clog2(DEPTH):0] count;

  ps2_key_fifo #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .ev_valid(ev_valid), .ev_code(ev_code), .ev_break(ev_break),
    .ev_ext(ev_ext), .count(count), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;

  // reference model: queue of {ext, brk, code}, prefix flags, sticky overflow
  logic [9:0] q[$];
  bit m_ext, m_brk, m_ovf;

  always @(negedge CLK) if (frame_err === 1'b1) err_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] h;
    h = (q.size() != 0) ? q[0] : 10'd0;
    check({tag, ".valid"}, ev_valid, q.size() != 0);
    check({tag, ".count"}, count, q.size());
    check({tag, ".ovf"}, overflow, m_ovf);
    check({tag, ".code"}, ev_code, h[7:0]);
    check({tag, ".ext"}, ev_ext, h[9]);
    check({tag, ".brk"}, ev_break, h[8]);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      if (BRK || !m_brk) begin
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back({m_ext, m_brk, b});
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input bit v);
    @(negedge CLK) ps2_data = v;
    repeat (10) @(negedge CLK);
    ps2_clk = 1'b0;
    repeat (20) @(negedge CLK);
    ps2_clk = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  // mode 0: plain; 1: check ev_valid latency on stop bit; 2: pop on the push edge
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int mode);
    bit p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    @(negedge CLK) ps2_data = 1'b1;
    repeat (10) @(negedge CLK);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      repeat (FILTER + 4) @(negedge CLK);
      check("lat_early", ev_valid, 0);
      @(negedge CLK);
      check("lat_ontime", ev_valid, 1);
      repeat (20 - FILTER - 5) @(negedge CLK);
    end else if (mode == 2) begin
      repeat (FILTER + 4) @(negedge CLK);
      rd_en = 1'b1;
      @(negedge CLK);
      rd_en = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      repeat (20 - FILTER - 5) @(negedge CLK);
    end else begin
      repeat (20) @(negedge CLK);
    end
    ps2_clk = 1'b1;
    repeat (10) @(negedge CLK);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input int mode);
    int e0;
    e0 = err_seen;
    send_frame(b, bad_par, mode);
    check("frame_err", err_seen - e0, bad_par ? 1 : 0);
    if (!bad_par) model_byte(b);
  endtask

  task automatic pop_one();
    @(negedge CLK) rd_en = 1'b1;
    @(negedge CLK) rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_all("pop");
  endtask

  task automatic drain();
    while (q.size() != 0) pop_one();
  endtask

  task automatic do_reset();
    @(negedge CLK) reset = 1'b1;
    q.delete(); m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    @(negedge CLK) reset = 1'b0;
  endtask

  initial begin
    int e0;
    logic [7:0] b;
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0;
    q.delete(); m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    repeat (3) @(negedge CLK);
    check_all("reset");
    check("reset.ferr", frame_err, 0);
    reset = 1'b0;
    repeat (5) @(negedge CLK);

    // single make code with latency check
    frame(8'h1C, 1'b0, 1);
    check_all("make1c");
    drain();

    // extended release
    frame(8'hE0, 1'b0, 0);
    frame(8'hF0, 1'b0, 0);
    frame(8'h75, 1'b0, 0);
    check_all("ext_brk");
    check("ext_brk.cnt", count, BRK ? 1 : 0);
    drain();

    // parity error then recovery
    frame(8'h1C, 1'b1, 0);
    check_all("par_err");
    frame(8'h29, 1'b0, 0);
    check_all("after_par");
    drain();

    // truncated frame aborted by timeout
    e0 = err_seen;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    repeat (TIMEOUT + FILTER + 4) @(negedge CLK);
    check("timeout_err", err_seen - e0, 1);
    frame(8'h5A, 1'b0, 0);
    check_all("after_to");
    drain();

    // overflow with nine make codes
    do_reset();
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 0);
    check_all("ovf_full");
    drain();

    // push and pop on the same edge while full
    do_reset();
    for (int i = 0; i < 8; i++) frame(8'h11 + 8'(i), 1'b0, 0);
    frame(8'h19, 1'b0, 2);
    check_all("full_pushpop");

    // reset in the middle of a frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    @(negedge CLK) reset = 1'b1;
    q.delete(); m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    @(negedge CLK);
    check_all("midreset");
    check("midreset.ferr", frame_err, 0);
    reset = 1'b0;
    repeat (50) @(negedge CLK);
    frame(8'h33, 1'b0, 0);
    check_all("after_rst");

    // randomized frames with random pops
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: b = 8'($urandom_range(1, 254));
      endcase
      frame(b, $urandom_range(0, 7) == 0, 0);
      check_all("rand");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) pop_one();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
